instr_exec_unit: RTL and testbench
==================================

Name: instr_exec_unit

Overview:
- Execution stage directly downstream of the instruction register.
- Accepts one decoded instruction (opcode, two signed 32-bit operands, register address) per handshake.
- Computes the 64-bit signed result and presents it with the originating address for write-back into the register's result field.
- ZERO/PASSA/PASSB/ADD/SUB/MULT complete in one cycle. DIV/MOD/POW are iterative with a fixed 32-step latency.

Parameters:
ITER_STEPS, 32, iteration count for DIV/MOD/POW; equals operand width, not to be changed independently
ERR_ON_BAD_OPC, 1, when 1, opcodes 9..15 set err_out; when 0, they silently return 0

Ports:
clk  input  1  clock; one clock, all logic on rising edge
reset  input  1  one clock; reset is synchronous and active-high
in_valid  input  1  instruction present
in_ready  output  1  unit can accept this cycle
in_opc  input  4  opcode_t
in_op_a  input  32  operand_t, signed
in_op_b  input  32  operand_t, signed
in_addr  input  5  address_t of source register entry
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_res  output  64  result_t, signed
out_addr  output  5  address copied from accepted instruction
err_out  output  1  divide-by-zero, or bad opcode when ERR_ON_BAD_OPC=1
busy  output  1  iterative operation in progress

Behaviour:
- States: IDLE, ITER_DIV, ITER_POW, DONE. Reset value is IDLE.
- Reset: out_valid=0, out_res=0, out_addr=0, err_out=0, busy=0, in_ready=1. A reset mid-iteration drops the in-flight instruction with no output.
- Accept: happens when in_valid && in_ready at a rising edge; opc/op_a/op_b/addr are captured.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back accept in the same cycle as result retire is legal.
- Single-cycle ops go to DONE; out_valid is high from the edge after accept.
- Iterative ops go to ITER_*; busy is high for ITER_STEPS cycles; then DONE. out_valid is high from the (ITER_STEPS+1)th edge after accept.
- DONE holds out_res/out_addr/err_out stable while out_valid && !out_ready. Retire goes to IDLE, or to the next op if a new accept occurs on the same edge.
- ZERO -> 0.
- PASSA/PASSB -> sign-extended op_a / op_b.
- ADD/SUB -> sign-extend both operands to 64 bits, then add/subtract. No overflow is possible.
- MULT -> full 64-bit signed product.
- DIV -> truncates toward zero. MOD -> remainder takes the dividend's sign (SystemVerilog / and % semantics).
  - Implemented as a restoring divider on magnitudes, with a sign fix applied in the final step.
  - -2^31 / -1 = +2^31; this is exact in 64 bits.
- op_b==0 for DIV/MOD: result 0, err_out=1, full latency still taken.
- POW -> op_a ** op_b by square-and-multiply over the 32 bits of op_b, MSB first. Arithmetic wraps modulo 2^64, two's complement.
  - op_b==0 -> 1, including 0**0.
  - op_b<0 -> 0, err_out=0.
- Opcodes 9..15 -> single-cycle, result 0, err_out=ERR_ON_BAD_OPC.
- err_out is valid only with out_valid and is cleared on retire.
- Inputs are ignored whenever in_ready=0.

Decomposition:
- Shared package additions:
  - exec_state_t enum {IDLE, ITER_DIV, ITER_POW, DONE}
  - constant EXEC_ITER_STEPS=32
  - function is_iterative(opcode_t)
- Reuse opcode_t, operand_t, result_t, address_t from the package.
- Sub-module instr_iter_divider: serial restoring 32-bit unsigned divider with start/done, quotient and remainder. The top owns the sign handling, the POW datapath and the handshake.

Test Plan:
- Reset, then ADD a=-5 b=12 addr=3, out_ready=1 -> out_valid one edge after accept, res=7, addr=3, err=0.
- MULT a=-2^31 b=-2^31 -> res=4611686018427387904 after one cycle. SUB a=-2^31 b=1 -> res=-2147483649.
- DIV a=-7 b=2 -> res=-3 exactly 33 edges after accept, busy high 32 cycles. MOD a=-7 b=2 -> -1. DIV a=5 b=0 -> res=0, err=1.
- POW a=3 b=5 -> 243; a=2 b=63 -> -2^63 (wrap); a=0 b=0 -> 1; a=2 b=-1 -> 0. Each at 33-edge latency.
- Backpressure: hold out_ready=0 for 10 cycles after PASSA a=42 -> out_res/out_addr stable, in_ready=0. Release together with a queued ADD -> retire and accept on the same edge, ADD result next cycle.
- Assert reset at step 15 of a DIV -> next cycle all outputs at reset values, no stale out_valid. A following PASSB b=9 returns 9.

Source files
------------

// File: rtl/instr_exec_unit_pkg.sv
// Shared types and constants for the execution stage that sits behind the instruction register.
// Opcodes 9..15 are deliberately left unassigned so the top can flag them as illegal.
package instr_exec_unit_pkg;

    localparam int OPERAND_W       = 32;
    localparam int EXEC_ITER_STEPS = 32;

    typedef logic [3:0]                  opcode_t;
    typedef logic signed [OPERAND_W-1:0] operand_t;
    typedef logic signed [63:0]          result_t;
    typedef logic [4:0]                  address_t;

    localparam opcode_t OPC_ZERO  = 4'd0;
    localparam opcode_t OPC_PASSA = 4'd1;
    localparam opcode_t OPC_PASSB = 4'd2;
    localparam opcode_t OPC_ADD   = 4'd3;
    localparam opcode_t OPC_SUB   = 4'd4;
    localparam opcode_t OPC_MULT  = 4'd5;
    localparam opcode_t OPC_DIV   = 4'd6;
    localparam opcode_t OPC_MOD   = 4'd7;
    localparam opcode_t OPC_POW   = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        ITER_DIV,
        ITER_POW,
        DONE
    } exec_state_t;

    function automatic logic is_iterative(input opcode_t opc);
        return (opc == OPC_DIV) || (opc == OPC_MOD) || (opc == OPC_POW);
    endfunction

endpackage

// File: rtl/instr_iter_divider.sv
// Serial restoring unsigned divider, one quotient bit per cycle after a start pulse.
// o_done flags the final step; o_quotient/o_remainder are the values that step produces.
module instr_iter_divider
    import instr_exec_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [OPERAND_W-1:0] i_dividend,
    input  logic [OPERAND_W-1:0] i_divisor,
    output logic                 o_done,
    output logic [OPERAND_W-1:0] o_quotient,
    output logic [OPERAND_W-1:0] o_remainder
);

    localparam int CW = $clog2(OPERAND_W);
    localparam logic [CW-1:0] LAST_STEP = CW'(OPERAND_W - 1);

    logic                 r_busy;
    logic [CW-1:0]        r_count;
    logic [OPERAND_W-1:0] r_quot;
    logic [OPERAND_W-1:0] r_rem;
    logic [OPERAND_W-1:0] r_divisor;

    logic [OPERAND_W:0]   w_trial;
    logic                 w_fits;
    logic [OPERAND_W-1:0] w_remNext;
    logic [OPERAND_W-1:0] w_quotNext;

    // The dividend shifts out of r_quot MSB-first while quotient bits shift in at the bottom.
    assign w_trial    = {r_rem, r_quot[OPERAND_W-1]};
    assign w_fits     = (w_trial >= {1'b0, r_divisor});
    assign w_remNext  = w_fits ? (w_trial[OPERAND_W-1:0] - r_divisor) : w_trial[OPERAND_W-1:0];
    assign w_quotNext = {r_quot[OPERAND_W-2:0], w_fits};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (i_start) begin
            r_busy    <= 1'b1;
            r_count   <= '0;
            r_quot    <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
        end else if (r_busy) begin
            r_quot  <= w_quotNext;
            r_rem   <= w_remNext;
            r_count <= r_count + CW'(1);
            if (r_count == LAST_STEP) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done      = r_busy && (r_count == LAST_STEP);
    assign o_quotient  = w_quotNext;
    assign o_remainder = w_remNext;

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage: single-cycle ALU ops plus iterative DIV/MOD/POW, with a valid/ready
// handshake on both sides and the source address carried through for write-back.
module instr_exec_unit
    import instr_exec_unit_pkg::*;
#(
    parameter int ITER_STEPS     = EXEC_ITER_STEPS,
    parameter bit ERR_ON_BAD_OPC = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     in_valid,
    output logic     in_ready,
    input  opcode_t  in_opc,
    input  operand_t in_op_a,
    input  operand_t in_op_b,
    input  address_t in_addr,
    output logic     out_valid,
    input  logic     out_ready,
    output result_t  out_res,
    output address_t out_addr,
    output logic     err_out,
    output logic     busy
);

    localparam int CW = $clog2(ITER_STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(ITER_STEPS - 1);

    exec_state_t r_state;
    exec_state_t w_nextState;
    exec_state_t w_acceptState;
    logic        w_accept;
    logic        w_retire;

    result_t  r_res;
    address_t r_addr;
    logic     r_err;

    logic r_isMod;
    logic r_negQuot;
    logic r_negRem;
    logic r_divZero;

    result_t       r_powAcc;
    result_t       r_powBase;
    operand_t      r_powExp;
    logic          r_powNegExp;
    logic [CW-1:0] r_powCount;

    result_t w_aExt;
    result_t w_bExt;
    result_t w_singleRes;
    logic    w_singleErr;

    logic                 w_divStart;
    logic                 w_divDone;
    logic [OPERAND_W-1:0] w_aMag;
    logic [OPERAND_W-1:0] w_bMag;
    logic [OPERAND_W-1:0] w_quot;
    logic [OPERAND_W-1:0] w_rem;
    result_t              w_quotSigned;
    result_t              w_remSigned;
    result_t              w_divRes;

    result_t w_powSq;
    result_t w_powNext;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_retire  = (r_state == DONE) && out_ready;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == ITER_DIV) || (r_state == ITER_POW);
    assign out_res   = r_res;
    assign out_addr  = r_addr;
    assign err_out   = r_err;

    assign w_aExt = {{32{in_op_a[OPERAND_W-1]}}, in_op_a};
    assign w_bExt = {{32{in_op_b[OPERAND_W-1]}}, in_op_b};

    always_comb begin
        w_singleRes = '0;
        w_singleErr = 1'b0;
        case (in_opc)
            OPC_ZERO:  w_singleRes = '0;
            OPC_PASSA: w_singleRes = w_aExt;
            OPC_PASSB: w_singleRes = w_bExt;
            OPC_ADD:   w_singleRes = w_aExt + w_bExt;
            OPC_SUB:   w_singleRes = w_aExt - w_bExt;
            OPC_MULT:  w_singleRes = w_aExt * w_bExt;
            OPC_DIV, OPC_MOD, OPC_POW: w_singleRes = '0;
            default:   w_singleErr = ERR_ON_BAD_OPC;
        endcase
    end

    // The divider works on magnitudes; -2^31 maps to the unsigned pattern 2^31, which is exact.
    assign w_aMag     = in_op_a[OPERAND_W-1] ? -in_op_a : in_op_a;
    assign w_bMag     = in_op_b[OPERAND_W-1] ? -in_op_b : in_op_b;
    assign w_divStart = w_accept && ((in_opc == OPC_DIV) || (in_opc == OPC_MOD));

    instr_iter_divider u_divider (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_divStart),
        .i_dividend  (w_aMag),
        .i_divisor   (w_bMag),
        .o_done      (w_divDone),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
    );

    assign w_quotSigned = r_negQuot ? -{32'd0, w_quot} : {32'd0, w_quot};
    assign w_remSigned  = r_negRem  ? -{32'd0, w_rem}  : {32'd0, w_rem};
    assign w_divRes     = r_divZero ? '0 : (r_isMod ? w_remSigned : w_quotSigned);

    assign w_powSq   = r_powAcc * r_powAcc;
    assign w_powNext = r_powExp[OPERAND_W-1] ? (w_powSq * r_powBase) : w_powSq;

    assign w_acceptState = !is_iterative(in_opc) ? DONE :
                           ((in_opc == OPC_POW) ? ITER_POW : ITER_DIV);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_nextState = w_acceptState;
            ITER_DIV: if (w_divDone) w_nextState = DONE;
            ITER_POW: if (r_powCount == LAST_STEP) w_nextState = DONE;
            DONE: begin
                if (w_accept) begin
                    w_nextState = w_acceptState;
                end else if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default:  w_nextState = IDLE;
        endcase
    end

    // Accept can only coincide with IDLE or a retiring DONE, never with an iteration step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res       <= '0;
            r_addr      <= '0;
            r_err       <= 1'b0;
            r_isMod     <= 1'b0;
            r_negQuot   <= 1'b0;
            r_negRem    <= 1'b0;
            r_divZero   <= 1'b0;
            r_powAcc    <= '0;
            r_powBase   <= '0;
            r_powExp    <= '0;
            r_powNegExp <= 1'b0;
            r_powCount  <= '0;
        end else begin
            if (w_accept) begin
                r_addr      <= in_addr;
                r_res       <= w_singleRes;
                r_err       <= w_singleErr;
                r_isMod     <= (in_opc == OPC_MOD);
                r_negQuot   <= in_op_a[OPERAND_W-1] ^ in_op_b[OPERAND_W-1];
                r_negRem    <= in_op_a[OPERAND_W-1];
                r_divZero   <= (in_op_b == 0);
                r_powAcc    <= 64'sd1;
                r_powBase   <= w_aExt;
                r_powExp    <= in_op_b;
                r_powNegExp <= in_op_b[OPERAND_W-1];
                r_powCount  <= '0;
            end else if (w_retire) begin
                r_err <= 1'b0;
            end

            if ((r_state == ITER_DIV) && w_divDone) begin
                r_res <= w_divRes;
                r_err <= r_divZero;
            end

            if (r_state == ITER_POW) begin
                r_powAcc   <= w_powNext;
                r_powExp   <= r_powExp << 1;
                r_powCount <= r_powCount + CW'(1);
                if (r_powCount == LAST_STEP) begin
                    r_res <= r_powNegExp ? '0 : w_powNext;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Self-checking bench: directed cases plus randomized traffic, compared every cycle against a
// behavioural model that tracks outstanding work in terms of latency and plain 64-bit arithmetic.
module tb_instr_exec_unit;
    import instr_exec_unit_pkg::*;

    logic     clk = 1'b0;
    logic     reset = 1'b1;
    logic     in_valid = 1'b0;
    logic     in_ready;
    opcode_t  in_opc = '0;
    operand_t in_op_a = '0;
    operand_t in_op_b = '0;
    address_t in_addr = '0;
    logic     out_valid;
    logic     out_ready = 1'b1;
    result_t  out_res;
    address_t out_addr;
    logic     err_out;
    logic     busy;

    instr_exec_unit #(.ITER_STEPS(32), .ERR_ON_BAD_OPC(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opc    (in_opc),
        .in_op_a   (in_op_a),
        .in_op_b   (in_op_b),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_addr  (out_addr),
        .err_out   (err_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checkCount++;
        $display("[TB] FAIL %s: wait bound expired, got no progress, expected completion at %0t", name, $time);
    endtask

    // Reference arithmetic straight from the opcode definitions.
    function automatic longint modelPow(input int a, input int b);
        longint acc = 1;
        longint base = longint'(a);
        int unsigned e = b;
        if (b < 0) return 0;
        while (e != 0) begin
            if (e[0]) acc = acc * base;
            base = base * base;
            e = e >> 1;
        end
        return acc;
    endfunction

    function automatic longint modelResult(input int opc, input int a, input int b);
        case (opc)
            0: return 0;
            1: return longint'(a);
            2: return longint'(b);
            3: return longint'(a) + longint'(b);
            4: return longint'(a) - longint'(b);
            5: return longint'(a) * longint'(b);
            6: return (b == 0) ? 0 : longint'(a) / longint'(b);
            7: return (b == 0) ? 0 : longint'(a) % longint'(b);
            8: return modelPow(a, b);
            default: return 0;
        endcase
    endfunction

    function automatic bit modelErr(input int opc, input int b);
        if ((opc == 6 || opc == 7) && b == 0) return 1'b1;
        return opc >= 9;
    endfunction

    function automatic int modelLatency(input int opc);
        return (opc >= 6 && opc <= 8) ? 33 : 1;
    endfunction

    bit     armed = 0;
    bit     justReset = 0;
    bit     mValid = 0;
    int     pendLeft = 0;
    longint pendRes = 0;
    int     pendAddr = 0;
    bit     pendErr = 0;
    longint curRes = 0;
    int     curAddr = 0;
    bit     curErr = 0;
    bit     readyExp;
    bit     retireNow;
    bit     acceptNow;
    int     latNow;

    always @(negedge clk) begin
        readyExp = (pendLeft == 0) && (!mValid || out_ready);
        if (armed) begin
            checkOutput("out_valid", longint'(out_valid), longint'(mValid));
            checkOutput("in_ready", longint'(in_ready), longint'(readyExp));
            checkOutput("busy", longint'(busy), longint'(pendLeft > 0));
            if (mValid) begin
                checkOutput("out_res", out_res, curRes);
                checkOutput("out_addr", longint'(out_addr), longint'(curAddr));
                checkOutput("err_out", longint'(err_out), longint'(curErr));
            end
            if (justReset) begin
                checkOutput("reset_out_res", out_res, 0);
                checkOutput("reset_out_addr", longint'(out_addr), 0);
                checkOutput("reset_err_out", longint'(err_out), 0);
            end
        end
        if (reset) begin
            armed     = 1;
            justReset = 1;
            mValid    = 0;
            pendLeft  = 0;
        end else if (armed) begin
            justReset = 0;
            retireNow = mValid && out_ready;
            acceptNow = in_valid && readyExp;
            if (pendLeft > 0) begin
                pendLeft--;
                if (pendLeft == 0) begin
                    mValid  = 1;
                    curRes  = pendRes;
                    curAddr = pendAddr;
                    curErr  = pendErr;
                end
            end
            if (retireNow) mValid = 0;
            if (acceptNow) begin
                latNow = modelLatency(int'(in_opc));
                if (latNow == 1) begin
                    mValid  = 1;
                    curRes  = modelResult(int'(in_opc), in_op_a, in_op_b);
                    curAddr = int'(in_addr);
                    curErr  = modelErr(int'(in_opc), in_op_b);
                end else begin
                    pendLeft = latNow - 1;
                    pendRes  = modelResult(int'(in_opc), in_op_a, in_op_b);
                    pendAddr = int'(in_addr);
                    pendErr  = modelErr(int'(in_opc), in_op_b);
                end
            end
        end
    end

    bit randReady = 0;

    always @(posedge clk) begin
        if (randReady) begin
            #1;
            if (randReady) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic applyStimulus(input opcode_t opc, input int a, input int b, input address_t addr);
        bit accepted = 0;
        int waited = 0;
        in_valid = 1'b1;
        in_opc   = opc;
        in_op_a  = a;
        in_op_b  = b;
        in_addr  = addr;
        while (!accepted) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #2;
            waited++;
            if (!accepted && waited > 200) begin
                reportTimeout("accept_wait");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drainResults();
        int waited = 0;
        randReady = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        while (mValid || pendLeft > 0) begin
            @(posedge clk);
            #2;
            waited++;
            if (waited > 100) begin
                reportTimeout("drain_wait");
                break;
            end
        end
    endtask

    function automatic int pickOperand();
        case ($urandom_range(0, 5))
            0: return int'($urandom());
            1: return int'($urandom_range(0, 20)) - 10;
            2: return int'(32'h8000_0000);
            3: return int'(32'h7fff_ffff);
            4: return 0;
            default: return -1;
        endcase
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] opc;
        int a;
        int b;

        checkOutput("pin_add", modelResult(OPC_ADD, -5, 12), 7);
        checkOutput("pin_mult", modelResult(OPC_MULT, int'(32'h8000_0000), int'(32'h8000_0000)), 64'sd4611686018427387904);
        checkOutput("pin_sub", modelResult(OPC_SUB, int'(32'h8000_0000), 1), -64'sd2147483649);
        checkOutput("pin_div", modelResult(OPC_DIV, -7, 2), -3);
        checkOutput("pin_mod", modelResult(OPC_MOD, -7, 2), -1);
        checkOutput("pin_div_min", modelResult(OPC_DIV, int'(32'h8000_0000), -1), 64'sd2147483648);
        checkOutput("pin_div0_err", longint'(modelErr(OPC_DIV, 0)), 1);
        checkOutput("pin_pow", modelPow(3, 5), 243);
        checkOutput("pin_pow_wrap", modelPow(2, 63), longint'(64'h8000_0000_0000_0000));
        checkOutput("pin_pow_00", modelPow(0, 0), 1);
        checkOutput("pin_pow_neg", modelPow(2, -1), 0);
        checkOutput("pin_latency", longint'(modelLatency(OPC_DIV)), 33);

        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        applyStimulus(OPC_ADD, -5, 12, 5'd3);
        applyStimulus(OPC_MULT, int'(32'h8000_0000), int'(32'h8000_0000), 5'd4);
        applyStimulus(OPC_SUB, int'(32'h8000_0000), 1, 5'd5);
        applyStimulus(OPC_DIV, -7, 2, 5'd6);
        applyStimulus(OPC_MOD, -7, 2, 5'd7);
        applyStimulus(OPC_DIV, 5, 0, 5'd8);
        applyStimulus(OPC_DIV, int'(32'h8000_0000), -1, 5'd9);
        applyStimulus(OPC_POW, 3, 5, 5'd10);
        applyStimulus(OPC_POW, 2, 63, 5'd11);
        applyStimulus(OPC_POW, 0, 0, 5'd12);
        applyStimulus(OPC_POW, 2, -1, 5'd13);
        applyStimulus(4'd12, 1, 2, 5'd14);
        drainResults();

        out_ready = 1'b0;
        applyStimulus(OPC_PASSA, 42, 0, 5'd7);
        in_valid = 1'b1;
        in_opc   = OPC_ADD;
        in_op_a  = 100;
        in_op_b  = -1;
        in_addr  = 5'd9;
        idleCycles(10);
        out_ready = 1'b1;
        idleCycles(1);
        in_valid = 1'b0;
        drainResults();

        applyStimulus(OPC_DIV, -100, 7, 5'd12);
        idleCycles(14);
        reset = 1'b1;
        idleCycles(1);
        reset = 1'b0;
        applyStimulus(OPC_PASSB, 0, 9, 5'd4);
        drainResults();

        randReady = 1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 4) == 0) opc = 4'($urandom_range(9, 15));
            else                           opc = 4'($urandom_range(0, 8));
            a = pickOperand();
            b = pickOperand();
            if (opc == OPC_POW && $urandom_range(0, 1) == 1) b = int'($urandom_range(0, 70));
            applyStimulus(opc, a, b, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 3)));
        end
        drainResults();
        idleCycles(2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
